// File: rtl/pushbutton_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// pushbutton_step_ctrl_if
//
// Bundles the button inputs and the count/strobe outputs of the push-button
// step controller.
//   master : drives the raw buttons and lock, observes the count side
//   slave  : the controller itself (consumes buttons, produces count)
//
// Signals:
//   btn_up, btn_down, btn_clr : raw asynchronous buttons, high = pressed
//   lock                      : synchronous, discards up/down steps
//   count[WIDTH]              : current count value
//   up_pulse / dn_pulse       : one-cycle strobe in the cycle count moved
//   at_limit                  : high while count is 0 or all-ones
// ---------------------------------------------------------------------------
interface pushbutton_step_ctrl_if #(
    parameter int WIDTH = 9
);
    logic             btn_up;
    logic             btn_down;
    logic             btn_clr;
    logic             lock;
    logic [WIDTH-1:0] count;
    logic             up_pulse;
    logic             dn_pulse;
    logic             at_limit;

    modport master (
        output btn_up, btn_down, btn_clr, lock,
        input  count, up_pulse, dn_pulse, at_limit
    );

    modport slave (
        input  btn_up, btn_down, btn_clr, lock,
        output count, up_pulse, dn_pulse, at_limit
    );
endinterface

// File: rtl/pushbutton_step_ctrl.sv
// ---------------------------------------------------------------------------
// pushbutton_step_ctrl
//
// Front end for push-button counters. Each raw button is synchronised (two
// flops) and debounced; the debounced up/down levels each drive a step FSM
// that issues a single step on press and auto-repeat steps while held. The
// debounced clear level issues one clear request on its rising edge. All
// requests are registered and applied to the count register one cycle later
// with a fixed priority: clear > lock > up/down collision > single step.
//
// Ports:
//   clk  : system clock, everything on posedge
//   rst  : synchronous active-high reset
//   bus  : pushbutton_step_ctrl_if.slave (buttons, lock, count, strobes,
//          at_limit)
//
// Latency from the first sample of a raw level change to the count update
// is DB_CYCLES+3 edges: 2 (synchroniser) + DB_CYCLES-1 (debounce run, db
// flips on the edge the run would reach DB_CYCLES) + 1 (registered request)
// + 1 (count register).
// ---------------------------------------------------------------------------
module pushbutton_step_ctrl #(
    parameter int WIDTH       = 9,
    parameter int DB_CYCLES   = 500000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int RPT_CYCLES  = 5000000,
    parameter bit WRAP        = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    pushbutton_step_ctrl_if.slave  bus
);

    localparam int NBTN    = 3;
    localparam int BTN_UP  = 0;
    localparam int BTN_DN  = 1;
    localparam int BTN_CLR = 2;

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } step_state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] db_level;
    logic [1:0]      step_req;     // [0] = up, [1] = down

    assign btn_raw = {bus.btn_clr, bus.btn_down, bus.btn_up};

    // -----------------------------------------------------------------------
    // Synchroniser + debounce, one per button.
    // The run counter only advances while the synced level disagrees with
    // the accepted level; any agreeing cycle restarts the run, so bounces
    // shorter than DB_CYCLES never flip db.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic [DB_W-1:0] run_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    run_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == db_reg) begin
                        run_reg <= '0;
                    end else if (run_reg == DB_LAST) begin
                        db_reg  <= ~db_reg;
                        run_reg <= '0;
                    end else begin
                        run_reg <= run_reg + 1'b1;
                    end
                end
            end

            assign db_level[gi] = db_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Step FSMs for up (gi=0) and down (gi=1). The request is a registered
    // one-cycle output. Releasing the button always wins over a timer
    // expiry in the same cycle.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_step
            step_state_t      state_reg;
            logic [TMR_W-1:0] timer_reg;
            logic             req_reg;
            logic             level;

            assign level = db_level[(gi == 0) ? BTN_UP : BTN_DN];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= S_IDLE;
                    timer_reg <= '0;
                    req_reg   <= 1'b0;
                end else begin
                    req_reg <= 1'b0;
                    case (state_reg)
                        S_IDLE: begin
                            if (level) begin
                                req_reg   <= 1'b1;
                                timer_reg <= '0;
                                state_reg <= S_HOLD;
                            end
                        end
                        S_HOLD: begin
                            if (!level) begin
                                state_reg <= S_IDLE;
                            end else if (timer_reg == HOLD_LAST) begin
                                req_reg   <= 1'b1;
                                timer_reg <= '0;
                                state_reg <= S_REPEAT;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end
                        S_REPEAT: begin
                            if (!level) begin
                                state_reg <= S_IDLE;
                            end else if (timer_reg == RPT_LAST) begin
                                req_reg   <= 1'b1;
                                timer_reg <= '0;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= S_IDLE;
                            timer_reg <= '0;
                        end
                    endcase
                end
            end

            assign step_req[gi] = req_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Clear request: rising edge of the debounced clear level only, so a
    // held clear button acts once.
    // -----------------------------------------------------------------------
    logic clr_prev_reg;
    logic clr_req_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_prev_reg <= 1'b0;
            clr_req_reg  <= 1'b0;
        end else begin
            clr_prev_reg <= db_level[BTN_CLR];
            clr_req_reg  <= db_level[BTN_CLR] & ~clr_prev_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Count register with arbitration.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] count_reg;
    logic             up_pulse_reg;
    logic             dn_pulse_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            up_pulse_reg <= 1'b0;
            dn_pulse_reg <= 1'b0;
        end else begin
            up_pulse_reg <= 1'b0;
            dn_pulse_reg <= 1'b0;
            if (clr_req_reg) begin
                count_reg <= '0;
            end else if (!bus.lock && (step_req[0] != step_req[1])) begin
                if (step_req[0]) begin
                    if (WRAP || (count_reg != CNT_MAX)) begin
                        count_reg    <= count_reg + 1'b1;
                        up_pulse_reg <= 1'b1;
                    end
                end else begin
                    if (WRAP || (count_reg != '0)) begin
                        count_reg    <= count_reg - 1'b1;
                        dn_pulse_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.count    = count_reg;
    assign bus.up_pulse = up_pulse_reg;
    assign bus.dn_pulse = dn_pulse_reg;
    assign bus.at_limit = (count_reg == '0) || (count_reg == CNT_MAX);

endmodule

// File: tb/tb_pushbutton_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pushbutton_step_ctrl
//
// Two controllers (WRAP=1 and WRAP=0) share the same button stimulus. A
// behavioural model predicts both every cycle: debounce as a run length of
// disagreeing samples, step requests as arithmetic on the time since the
// debounced press began, and the arbitration rules applied to two counts.
// ---------------------------------------------------------------------------
module tb_pushbutton_step_ctrl;

    localparam int WIDTH = 9;
    localparam int DB    = 4;
    localparam int HOLD  = 20;
    localparam int RPT   = 5;
    localparam int MAXV  = 511;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0, lock = 1'b0;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    pushbutton_step_ctrl_if #(.WIDTH(WIDTH)) if0 ();
    pushbutton_step_ctrl_if #(.WIDTH(WIDTH)) if1 ();

    assign if0.btn_up = btn_up;  assign if0.btn_down = btn_down;
    assign if0.btn_clr = btn_clr; assign if0.lock = lock;
    assign if1.btn_up = btn_up;  assign if1.btn_down = btn_down;
    assign if1.btn_clr = btn_clr; assign if1.lock = lock;

    pushbutton_step_ctrl #(.WIDTH(WIDTH), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
                           .RPT_CYCLES(RPT), .WRAP(1'b1))
        dut_wrap (.clk(clk), .rst(rst), .bus(if0));

    pushbutton_step_ctrl #(.WIDTH(WIDTH), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
                           .RPT_CYCLES(RPT), .WRAP(1'b0))
        dut_sat (.clk(clk), .rst(rst), .bus(if1));

    // ---------------- reference model ----------------
    int m_s1[3], m_s2[3], m_db[3], m_run[3], m_rise[3];
    int m_edge = 0;
    bit m_req_up, m_req_dn, m_req_clr;
    int m_cnt[2];
    bit m_up[2], m_dn[2];

    // Steps are due at 0, HOLD, HOLD+RPT, ... edges after the first request.
    function automatic bit step_due(int n);
        return (n == 0) || (n >= HOLD && ((n - HOLD) % RPT) == 0);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_run[b] = 0; m_rise[b] = -1000;
        end
        m_req_up = 0; m_req_dn = 0; m_req_clr = 0;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_up[d] = 0; m_dn[d] = 0;
        end
    endtask

    task automatic model_step();
        int r[3];
        bit n_up, n_dn, n_clr;
        r[0] = int'(btn_up); r[1] = int'(btn_down); r[2] = int'(btn_clr);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_up[d] = 0; m_dn[d] = 0;
                if (m_req_clr) begin
                    m_cnt[d] = 0;
                end else if (!lock && (m_req_up != m_req_dn)) begin
                    if (m_req_up) begin
                        if (!(d == 1 && m_cnt[d] == MAXV)) begin
                            m_cnt[d] = (m_cnt[d] + 1) % (MAXV + 1);
                            m_up[d] = 1;
                        end
                    end else begin
                        if (!(d == 1 && m_cnt[d] == 0)) begin
                            m_cnt[d] = (m_cnt[d] + MAXV) % (MAXV + 1);
                            m_dn[d] = 1;
                        end
                    end
                end
            end
            n_up  = (m_db[0] != 0) && step_due(m_edge - m_rise[0] - 1);
            n_dn  = (m_db[1] != 0) && step_due(m_edge - m_rise[1] - 1);
            n_clr = (m_db[2] != 0) && (m_rise[2] == m_edge - 1);
            for (int b = 0; b < 3; b++) begin
                if (m_s2[b] != m_db[b]) begin
                    if (m_run[b] == DB - 1) begin
                        m_db[b] = 1 - m_db[b];
                        m_run[b] = 0;
                        if (m_db[b] != 0) m_rise[b] = m_edge;
                    end else begin
                        m_run[b]++;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = r[b];
            end
            m_req_up = n_up; m_req_dn = n_dn; m_req_clr = n_clr;
        end
        m_edge++;
    endtask

    function automatic logic [23:0] exp_vec();
        logic a0, a1;
        a0 = (m_cnt[0] == 0) || (m_cnt[0] == MAXV);
        a1 = (m_cnt[1] == 0) || (m_cnt[1] == MAXV);
        return {WIDTH'(m_cnt[0]), m_up[0], m_dn[0], a0,
                WIDTH'(m_cnt[1]), m_up[1], m_dn[1], a1};
    endfunction

    function automatic logic [23:0] obs_vec();
        return {if0.count, if0.up_pulse, if0.dn_pulse, if0.at_limit,
                if1.count, if1.up_pulse, if1.dn_pulse, if1.at_limit};
    endfunction

    // One clock: model follows the same sampled inputs; outputs are read
    // at the following negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; btn_up = 0; btn_down = 0; btn_clr = 0; lock = 0;
        tick();
        rst = 1'b0;
    endtask

    // Stimulus-only press used to set up a starting count.
    task automatic press_up();
        for (int i = 0; i < 25; i++) begin
            btn_up = (i <= 9);
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; btn_up = 1; btn_down = 0; btn_clr = 0; lock = 0;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (obs_vec() !== {9'd0, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got %h expected %h", obs_vec(),
                     {9'd0, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1});
        end
        rst = 1'b0; btn_up = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_press();
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            btn_up = (i <= 9);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_press cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            tests_run++;
            if (if0.count !== ((i >= 7) ? 9'd1 : 9'd0) || if0.up_pulse !== (i == 7)) begin
                failures++;
                $display("FAIL single_press_plan cyc %0d count %0d up %b", i, if0.count, if0.up_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            btn_up = (i < 16) ? (((i / 2) % 2) == 0) : 1'b0;
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec() || if0.count !== 9'd0 || if0.up_pulse !== 1'b0) begin
                failures++;
                $display("FAIL bounce cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_auto_repeat();
        apply_reset();
        for (int i = 0; i < 55; i++) begin
            btn_up = (i <= 39);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL auto_repeat cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            tests_run++;
            if (if0.up_pulse !== (i == 7 || i == 27 || i == 32 || i == 37 || i == 42)) begin
                failures++;
                $display("FAIL auto_repeat_plan cyc %0d up_pulse %b", i, if0.up_pulse);
            end
        end
        tests_run++;
        if (if0.count !== 9'd5) begin
            failures++;
            $display("FAIL auto_repeat_final got %0d expected 5", if0.count);
        end
    endtask

    task automatic test_wrap_saturate();
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            btn_down = (i <= 9);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_down cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (if0.count !== 9'd511 || if1.count !== 9'd0) begin
            failures++;
            $display("FAIL wrap_down_plan wrap %0d sat %0d expected 511 and 0", if0.count, if1.count);
        end
        for (int i = 0; i < 25; i++) begin
            btn_up = (i <= 9);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_up cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (if0.count !== 9'd0 || if1.count !== 9'd1) begin
            failures++;
            $display("FAIL wrap_up_plan wrap %0d sat %0d expected 0 and 1", if0.count, if1.count);
        end
        // Hold up long enough for the saturating unit to reach its top.
        for (int i = 0; i < 2680; i++) begin
            btn_up = (i < 2650);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL saturate_hold cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i >= 2600) begin
                tests_run++;
                if (if1.count !== 9'd511 || if1.up_pulse !== 1'b0) begin
                    failures++;
                    $display("FAIL saturate_top cyc %0d count %0d up %b expected 511 and 0",
                             i, if1.count, if1.up_pulse);
                end
            end
        end
    endtask

    task automatic test_collisions();
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            btn_up = (i <= 9); btn_down = (i <= 9);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec() || if0.count !== 9'd0 || if0.up_pulse || if0.dn_pulse) begin
                failures++;
                $display("FAIL collide_updown cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        btn_down = 0;
        for (int k = 0; k < 3; k++) press_up();
        tests_run++;
        if (if0.count !== 9'd3) begin
            failures++;
            $display("FAIL collide_setup got %0d expected 3", if0.count);
        end
        for (int i = 0; i < 30; i++) begin
            btn_up = (i <= 9); btn_clr = (i <= 9);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec() || if0.up_pulse !== 1'b0 ||
                if0.count !== ((i >= 7) ? 9'd0 : 9'd3)) begin
                failures++;
                $display("FAIL collide_clr_up cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        btn_clr = 0;
        press_up();
        lock = 1'b1;
        for (int i = 0; i < 30; i++) begin
            btn_up = (i <= 9);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec() || if0.count !== 9'd1 || if0.up_pulse) begin
                failures++;
                $display("FAIL lock_up cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        lock = 1'b0;
    endtask

    task automatic test_reset_mid_repeat();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            btn_up = (i <= 80);
            rst = (i == 39);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 38 || i == 39 || i == 46 || i == 47) begin
                tests_run++;
                if (if0.count !== ((i == 38) ? 9'd4 : (i == 47) ? 9'd1 : 9'd0)) begin
                    failures++;
                    $display("FAIL reset_mid_plan cyc %0d count %0d", i, if0.count);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int hold_left[3];
        apply_reset();
        for (int b = 0; b < 3; b++) hold_left[b] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++) begin
                hold_left[b]--;
                if (hold_left[b] <= 0) begin
                    hold_left[b] = int'($urandom_range(1, 40));
                    case (b)
                        0: btn_up = ~btn_up;
                        1: btn_down = ~btn_down;
                        default: btn_clr = ($urandom_range(0, 3) == 0) ? ~btn_clr : 1'b0;
                    endcase
                end
            end
            if ($urandom_range(0, 49) == 0) lock = ~lock;
            rst = ($urandom_range(0, 399) == 0);
            tick();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        rst = 0; lock = 0; btn_up = 0; btn_down = 0; btn_clr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_wrap_saturate();
        test_collisions();
        test_reset_mid_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/pushbutton_step_ctrl.md
Name: pushbutton_step_ctrl

Overview:
- Front-end controller for the team's push-button counters. It takes three raw mechanical buttons (up, down, clear), synchronises and debounces each one, and sequences single-step and auto-repeat increments/decrements.
- It arbitrates simultaneous requests and owns the count register.
- It replaces direct edge-clocking of counters with a fully synchronous, single-clock design.

Parameters:
- WIDTH, 9, count width in bits.
- DB_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- HOLD_CYCLES, 25000000, cycles from the initial step request to the first auto-repeat step request.
- RPT_CYCLES, 5000000, cycles between auto-repeat step requests.
- WRAP, 1, 1 = modular wrap at the limits, 0 = saturate at the limits.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- btn_up, input, 1, raw asynchronous button; high = pressed.
- btn_down, input, 1, raw asynchronous button; high = pressed.
- btn_clr, input, 1, raw asynchronous button; high = pressed.
- lock, input, 1, synchronous; when high, up/down steps are discarded; clear still acts.
- count, output, WIDTH, current count value.
- up_pulse, output, 1, one-cycle strobe in the cycle count incremented.
- dn_pulse, output, 1, one-cycle strobe in the cycle count decremented.
- at_limit, output, 1, high while count is 0 or 2^WIDTH-1.

Behaviour:
- Reset:
  - Interface: one clock (clk); reset rst is synchronous and active-high.
  - While rst is high, the following clear to 0: synchroniser flops, debounced levels, debounce counters, FSM timers, count, up_pulse and dn_pulse.
  - Both step FSMs go to IDLE.
  - at_limit = 1 after reset, because count = 0.
- Synchroniser: two flops per button; 2-cycle latency.
- Debounce (per button):
  - The counter increments while the synced level differs from the debounced level db.
  - It clears to 0 on any cycle the two agree.
  - When the counter reaches DB_CYCLES, db toggles and the counter clears.
- Step FSM (one each for up and down), states IDLE, HOLD, REPEAT:
  - IDLE: db high -> issue a step request (1 cycle), clear the timer, go to HOLD.
  - HOLD: timer counts; db low -> IDLE, no request. Timer = HOLD_CYCLES-1 -> issue a request, clear the timer, go to REPEAT.
  - REPEAT: db low -> IDLE. Timer = RPT_CYCLES-1 -> issue a request, clear the timer.
  - A FSM that sees db low in any state returns to IDLE in that cycle without issuing a request.
- Clear: the rising edge of db_clr issues a clear request (1 cycle). Holding clear does not repeat.
- Arbitration, applied at the count register one cycle after the requests:
  1. A clear request sets count to 0. Same-cycle up/down requests are dropped and neither pulse fires.
  2. lock = 1: up/down requests are dropped.
  3. Up and down requests in the same cycle: no change, no pulse.
  4. A single up request: count+1, up_pulse = 1.
  5. A single down request: count-1, dn_pulse = 1.
- Limits:
  - WRAP=1: 2^WIDTH-1 +1 -> 0, and 0 -1 -> 2^WIDTH-1. The pulse fires.
  - WRAP=0: the count is held at the limit and no pulse fires.
- Latency: raw level first sampled at edge k -> count updates at edge k+DB_CYCLES+3. Clear has the same latency.
- Button held through reset release:
  - Treated as a new press.
  - Step lands DB_CYCLES+3 cycles after the first edge with rst low.
- Reset mid-operation (any state, any timer value): everything returns to reset values on the next edge. No partially completed step survives.
- Bounces shorter than DB_CYCLES never change db and produce no step.

Test Plan:
All scenarios use WIDTH=9, DB_CYCLES=4, HOLD_CYCLES=20, RPT_CYCLES=5, WRAP=1; cycle numbers are relative to the first raw-high sample (edge 0).
- Single press: btn_up high for edges 0..9, then low -> count 0->1 at edge 7, up_pulse high only at edge 7; count stays 1 thereafter.
- Bounce rejection: btn_up toggles every 2 cycles for 16 cycles, then stays low -> count stays 0, no pulses.
- Auto-repeat: btn_up high for edges 0..39 -> count updates at edges 7, 27, 32, 37, 42; final count 5; no update at 47.
- Wrap and saturate: from 0, one btn_down press -> count 511, dn_pulse fires; then one btn_up press -> 0. Rerun with WRAP=0: down at 0 stays 0 with no pulse; up at 511 stays 511 with no pulse.
- Collisions:
  - btn_up and btn_down raised on the same edge -> no change, no pulses.
  - btn_clr and btn_up raised together with count=3 -> count 0 at edge 7, no up_pulse.
  - lock=1 during an up press -> no change.
- Reset mid-repeat: rst high for 1 cycle while in REPEAT with count=4 and btn_up still held -> count 0 next edge; count becomes 1 at 7 cycles after rst deasserts, then repeats resume per HOLD/RPT.
